// File: rtl/mc_mem_responder.sv
// mc_mem_responder: memory-side responder for the multicycle MIPS core.
// Accepts a req/we access into a word-addressed unified store and answers
// with a one-cycle ack LATENCY cycles after acceptance. After each ack it
// spends one recovery cycle, so a req still held high during the ack cycle
// cannot start a second access.
module mc_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic                  we_q;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  // Access attributes used at the edge that enters RESP. With LATENCY=1 that
  // edge is the acceptance edge itself, so the live inputs are used instead
  // of the latched copy.
  logic                  acc_we;
  logic [ADDR_WIDTH+1:0] acc_addr;
  logic [31:0]           acc_wdata;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  acc_misal;
  logic                  enter_resp;

  // Address bits above the word index are ignored, so accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_WIDTH+2];

  // Select live or latched access attributes.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == IDLE) begin
      acc_we    = we;
      acc_addr  = addr[ADDR_WIDTH+1:0];
      acc_wdata = wdata;
    end
    acc_idx    = acc_addr[ADDR_WIDTH+1:2];
    acc_misal  = |acc_addr[1:0];
    enter_resp = (state_next == RESP) && (state != RESP);
  end

  // Next-state and wait-counter logic. The counter holds the number of
  // cycles still to spend before RESP; RESP is entered on the edge where it
  // would decrement to zero, which places ack exactly LATENCY cycles after
  // the acceptance cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_next   = 4'(LATENCY - 1);
          state_next = (LATENCY <= 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_next   = '0;
          state_next = RESP;
        end
      end
      RESP:    state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control state, latched request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && req) begin
        we_q    <= we;
        addr_q  <= addr[ADDR_WIDTH+1:0];
        wdata_q <= wdata;
      end
      ack   <= (state_next == RESP);
      busy  <= (state_next == WAIT) || (state_next == RESP);
      err   <= enter_resp && acc_misal;
      rdata <= (enter_resp && !acc_we && !acc_misal) ? mem[acc_idx] : '0;
    end
  end

  // Store write on the edge entering RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && acc_we && !acc_misal)
      mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Directed testbench for mc_mem_responder: one instance with LATENCY=2 and
// one with LATENCY=4, sharing a clock.
module tb_mc_mem_responder;

  logic clk;
  logic rst2, req2, we2, ack2, err2, busy2;
  logic [31:0] addr2, wdata2, rdata2;
  logic rst4, req4, we4, ack4, err4, busy4;
  logic [31:0] addr4, wdata4, rdata4;

  int pass_cnt = 0;
  int total    = 0;

  mc_mem_responder #(.ADDR_WIDTH(6), .LATENCY(2)) dut2 (
    .clk(clk), .reset(rst2), .req(req2), .we(we2), .addr(addr2),
    .wdata(wdata2), .rdata(rdata2), .ack(ack2), .err(err2), .busy(busy2)
  );

  mc_mem_responder #(.ADDR_WIDTH(6), .LATENCY(4)) dut4 (
    .clk(clk), .reset(rst4), .req(req4), .we(we4), .addr(addr4),
    .wdata(wdata4), .rdata(rdata4), .ack(ack4), .err(err4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1);
  end

  task automatic drive(input int which, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    if (which == 2) begin
      req2 = r; we2 = w; addr2 = a; wdata2 = d;
    end else begin
      req4 = r; we4 = w; addr4 = a; wdata4 = d;
    end
  endtask

  // Runs one access; returns the ack cycle number (-1 on timeout), ack-cycle
  // rdata/err and the ack/rdata/busy seen in the following cycle.
  task automatic do_access(input int which, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output int n_ack,
                           output logic [31:0] rd, output logic er,
                           output logic ack_after, output logic [31:0] rd_after,
                           output logic busy_after);
    n_ack = -1; rd = 'x; er = 1'bx;
    @(negedge clk);
    drive(which, 1'b1, w, a, d);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if ((which == 2) ? ack2 : ack4) begin
        n_ack = n;
        rd = (which == 2) ? rdata2 : rdata4;
        er = (which == 2) ? err2 : err4;
        break;
      end
    end
    drive(which, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    ack_after  = (which == 2) ? ack2 : ack4;
    rd_after   = (which == 2) ? rdata2 : rdata4;
    busy_after = (which == 2) ? busy2 : busy4;
  endtask

  task automatic test_reset();
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
    rst2 = 1'b0; rst4 = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ack2, err2, busy2, rdata2, ack4, err4, busy4, rdata4} !== 70'b0)
      $display("FAIL reset_hold: actual=%b/%b/%b/%h required=0", ack2, err2, busy2, rdata2);
    else pass_cnt++;
    rst2 = 1'b1; rst4 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({ack2, err2, busy2, rdata2} !== 35'b0)
        $display("FAIL idle2_c%0d: actual ack=%b err=%b busy=%b rdata=%h required all 0",
                 c, ack2, err2, busy2, rdata2);
      else pass_cnt++;
      total++;
      if ({ack4, err4, busy4, rdata4} !== 35'b0)
        $display("FAIL idle4_c%0d: actual ack=%b err=%b busy=%b rdata=%h required all 0",
                 c, ack4, err4, busy4, rdata4);
      else pass_cnt++;
    end
  endtask

  task automatic test_store_load();
    int n; logic [31:0] rd, rda; logic er, aa, ba;
    do_access(2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, n, rd, er, aa, rda, ba);
    total++;
    if (n !== 2) $display("FAIL store_latency: actual=%0d required=2", n); else pass_cnt++;
    total++;
    if ({rd, er} !== 33'b0) $display("FAIL store_resp: actual rdata=%h err=%b required 0/0", rd, er);
    else pass_cnt++;
    total++;
    if (aa !== 1'b0) $display("FAIL store_ack_width: actual=%b required=0", aa); else pass_cnt++;
    do_access(2, 1'b0, 32'h0000_0010, 32'h0, n, rd, er, aa, rda, ba);
    total++;
    if (n !== 2) $display("FAIL load_latency: actual=%0d required=2", n); else pass_cnt++;
    total++;
    if (rd !== 32'hDEAD_BEEF) $display("FAIL load_data: actual=%h required=deadbeef", rd);
    else pass_cnt++;
    total++;
    if (er !== 1'b0) $display("FAIL load_err: actual=%b required=0", er); else pass_cnt++;
    total++;
    if ({aa, rda, ba} !== 34'b0)
      $display("FAIL load_recover: actual ack=%b rdata=%h busy=%b required all 0", aa, rda, ba);
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    int n; logic [31:0] rd, rda; logic er, aa, ba;
    do_access(2, 1'b1, 32'h0000_0012, 32'h1234_5678, n, rd, er, aa, rda, ba);
    total++;
    if ({n == 2, er, rd} !== {1'b1, 1'b1, 32'h0})
      $display("FAIL misaligned_resp: actual n=%0d err=%b rdata=%h required n=2 err=1 rdata=0", n, er, rd);
    else pass_cnt++;
    total++;
    if (aa !== 1'b0 || rda !== 32'h0)
      $display("FAIL misaligned_recover: actual ack=%b rdata=%h required 0/0", aa, rda);
    else pass_cnt++;
    do_access(2, 1'b0, 32'h0000_0010, 32'h0, n, rd, er, aa, rda, ba);
    total++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0)
      $display("FAIL misaligned_nowrite: actual rdata=%h err=%b required deadbeef/0", rd, er);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int n; logic [31:0] rd, rda; logic er, aa, ba;
    do_access(2, 1'b1, 32'h0000_0100, 32'hCAFE_0001, n, rd, er, aa, rda, ba);
    do_access(2, 1'b0, 32'h0000_0000, 32'h0, n, rd, er, aa, rda, ba);
    total++;
    if (rd !== 32'hCAFE_0001 || er !== 1'b0)
      $display("FAIL wrap_load: actual rdata=%h err=%b required cafe0001/0", rd, er);
    else pass_cnt++;
    do_access(2, 1'b0, 32'hFFFF_FF10, 32'h0, n, rd, er, aa, rda, ba);
    total++;
    if (rd !== 32'hDEAD_BEEF)
      $display("FAIL wrap_high_bits: actual rdata=%h required deadbeef", rd);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] pat;
    logic [31:0] rd2nd;
    logic late_ack;
    pat = '0; rd2nd = '0; late_ack = 1'b0;
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk);
      @(negedge clk);
      pat[n-1] = ack2;
      if (n == 6) rd2nd = rdata2;
    end
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int n = 7; n <= 9; n++) begin
      @(posedge clk);
      @(negedge clk);
      late_ack = late_ack | ack2;
    end
    total++;
    if (pat !== 6'b100010)
      $display("FAIL held_req_acks: actual pattern=%b required=100010", pat);
    else pass_cnt++;
    total++;
    if (rd2nd !== 32'hDEAD_BEEF)
      $display("FAIL held_req_data: actual=%h required=deadbeef", rd2nd);
    else pass_cnt++;
    total++;
    if (late_ack !== 1'b0 || busy2 !== 1'b0)
      $display("FAIL held_req_drain: actual ack=%b busy=%b required 0/0", late_ack, busy2);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n; logic [31:0] rd, rda; logic er, aa, ba;
    logic seen_ack;
    do_access(4, 1'b1, 32'h0000_0020, 32'h1111_1111, n, rd, er, aa, rda, ba);
    total++;
    if (n !== 4) $display("FAIL lat4_latency: actual=%0d required=4", n); else pass_cnt++;
    @(negedge clk);
    drive(4, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_5555);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    total++;
    if (busy4 !== 1'b1) $display("FAIL mid_busy_before: actual=%b required=1", busy4);
    else pass_cnt++;
    rst4 = 1'b0;
    drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    total++;
    if (busy4 !== 1'b0 || ack4 !== 1'b0)
      $display("FAIL mid_reset_outputs: actual busy=%b ack=%b required 0/0", busy4, ack4);
    else pass_cnt++;
    @(negedge clk);
    rst4 = 1'b1;
    seen_ack = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      seen_ack = seen_ack | ack4;
    end
    total++;
    if (seen_ack !== 1'b0) $display("FAIL mid_reset_noack: actual=%b required=0", seen_ack);
    else pass_cnt++;
    do_access(4, 1'b0, 32'h0000_0020, 32'h0, n, rd, er, aa, rda, ba);
    total++;
    if (rd !== 32'h1111_1111 || n !== 4)
      $display("FAIL mid_reset_nostore: actual rdata=%h n=%0d required 11111111/4", rd, n);
    else pass_cnt++;
  endtask

  initial begin
    rst2 = 1'b0; rst4 = 1'b0;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
    test_reset();
    test_store_load();
    test_misaligned();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
